// File: rtl/mod_exp_requester_pkg.sv
// Shared definitions for the mod_exp requester: FSM state encoding and default sizing.
package mod_exp_requester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 65535;

endpackage

// File: rtl/mod_exp_requester.sv
// Initiator for one mod_exp core: one job per message word with a latched key,
// results returned on a backpressured stream, each job bounded by a watchdog.
module mod_exp_requester
  import mod_exp_requester_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_exp,
  input  logic [WIDTH-1:0] key_mod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_msg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [WIDTH-1:0] me_base,
  output logic [WIDTH-1:0] me_exponent,
  output logic [WIDTH-1:0] me_modulo,
  output logic             me_valid,
  input  logic             me_ready,
  input  logic [WIDTH-1:0] me_result
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] key_exp_q, key_mod_q;
  logic             idle, load_key, accept, mod_zero, mod_one, timeout_hit;

  assign idle        = (state == ST_IDLE);
  assign load_key    = idle && key_load;
  assign accept      = idle && !key_load && in_valid;
  assign mod_zero    = (key_mod_q == '0);
  assign mod_one     = (key_mod_q == WIDTH'(1));
  // The GUARD cycle counts toward the budget, so the abort lands TIMEOUT+1 cycles after ISSUE.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  assign in_ready  = rst_n && idle && !key_load;
  assign me_valid  = (state == ST_ISSUE);
  assign out_valid = (state == ST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = (mod_zero || mod_one) ? ST_HOLD : ST_ISSUE;
      end
      ST_ISSUE: state_nx = ST_GUARD;
      ST_GUARD: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (me_ready || timeout_hit) state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_exp_q   <= '0;
      key_mod_q   <= '0;
      me_base     <= '0;
      me_exponent <= '0;
      me_modulo   <= '0;
      out_data    <= '0;
      out_err     <= 1'b0;
      cnt         <= '0;
    end else begin
      if (load_key) begin
        key_exp_q <= key_exp;
        key_mod_q <= key_mod;
      end
      // Operands are latched at acceptance and stay put until the next job.
      if (accept) begin
        me_base     <= in_msg;
        me_exponent <= key_exp_q;
        me_modulo   <= key_mod_q;
        out_data    <= '0;
        out_err     <= mod_zero;
      end
      case (state)
        ST_GUARD: cnt <= cnt + CNT_W'(1);
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (me_ready) begin
            out_data <= me_result;
            out_err  <= 1'b0;
          end else if (timeout_hit) begin
            out_data <= '0;
            out_err  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_requester.sv
// Bench for mod_exp_requester with a behavioural mod_exp core and a job-level reference model.
module tb_mod_exp_requester;

  localparam int W  = 32;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_load = 1'b0;
  logic [W-1:0] key_exp = '0, key_mod = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_msg = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_err;
  logic [W-1:0] me_base, me_exponent, me_modulo;
  logic         me_valid;
  logic         me_ready = 1'b0;
  logic [W-1:0] me_result = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mod_exp_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_exp(key_exp), .key_mod(key_mod),
    .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .me_base(me_base), .me_exponent(me_exponent), .me_modulo(me_modulo),
    .me_valid(me_valid), .me_ready(me_ready), .me_result(me_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] modexp(logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] m);
    logic [63:0] r, x;
    r = 64'(1) % 64'(m);
    x = 64'(b) % 64'(m);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return r[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural mod_exp core: result appears core_lat cycles after it sees the start,
  // and the previous ready/result stay visible for one cycle after the start pulse.
  int           core_lat = 1;
  logic         core_dead = 1'b0;
  logic         vld_d = 1'b0;
  int           core_cnt = 0;
  logic [W-1:0] cb = '0, ce = '0, cm = '0;
  int           mv_total = 0;

  always @(posedge clk) begin
    vld_d <= me_valid;
    if (me_valid) begin
      cb <= me_base; ce <= me_exponent; cm <= me_modulo;
      mv_total <= mv_total + 1;
    end
    if (vld_d) begin
      me_ready <= 1'b0;
      core_cnt <= core_lat;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_dead) begin
        me_ready  <= 1'b1;
        me_result <= modexp(cb, ce, cm);
      end
    end
  end

  // Reference model: one outstanding job, key honoured only when no job is outstanding.
  logic         busy = 1'b0;
  logic [W-1:0] mkey_e = '0, mkey_m = '0;
  logic [W-1:0] job_base = '0, job_exp = '0, job_mod = '0, exp_data = '0;
  logic         exp_err = 1'b0;
  int           mv = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; mkey_e <= '0; mkey_m <= '0;
    end else begin
      if (!busy) begin
        if (key_load) begin
          mkey_e <= key_exp; mkey_m <= key_mod;
        end else if (in_valid) begin
          busy     <= 1'b1;
          mv       <= 0;
          job_base <= in_msg; job_exp <= mkey_e; job_mod <= mkey_m;
          exp_err  <= (mkey_m == 0) || (mkey_m > 1 && core_dead);
          exp_data <= (mkey_m <= 1 || core_dead) ? '0 : modexp(in_msg, mkey_e, mkey_m);
        end
      end else if (out_valid && out_ready) begin
        busy <= 1'b0;
      end
      if (me_valid) mv <= mv + 1;
    end
  end

  int issue_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {in_ready, out_valid, out_err, me_valid, out_data, me_base}, 0);
      chk("reset_me_ops", {me_exponent, me_modulo}, 0);
    end else begin
      chk("in_ready", in_ready, !busy && !key_load);
      if (!busy) chk("spurious_out_valid", out_valid, 0);
      if (busy && out_valid) begin
        chk("out_data", out_data, exp_data);
        chk("out_err", out_err, exp_err);
        if (out_ready) chk("me_valid_pulses", mv, (job_mod > 1) ? 1 : 0);
      end
      if (me_valid) begin
        issue_cyc = cyc;
        chk("me_valid_busy", busy, 1);
        chk("me_ops", {me_base, me_exponent, me_modulo}, {job_base, job_exp, job_mod});
      end
    end
  end

  int hs_cyc = 0, ov_cyc = 0;

  task automatic load_key(input logic [W-1:0] e, input logic [W-1:0] m);
    @(posedge clk); #1;
    key_load = 1'b1; key_exp = e; key_mod = m;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] msg);
    bit done = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_msg = msg;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        hs_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      chk("in_handshake_wait", in_ready, 1);
      in_valid = 1'b0;
    end
  endtask

  task automatic get(input int hold, output logic [W-1:0] d, output logic e);
    for (int k = 0; k < 200 && !out_valid; k++) @(negedge clk);
    chk("out_valid_wait", out_valid, 1);
    ov_cyc = cyc; d = out_data; e = out_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_data", out_data, d);
      key_load = (k == 10); key_exp = 1; key_mod = 100;
    end
    key_load = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("back_to_idle", in_ready, 1);
  endtask

  logic [W-1:0] d;
  logic         e;
  int           mv0, ov_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("model_4_13_497", modexp(4, 13, 497), 445);
    chk("model_3_0_7", modexp(3, 0, 7), 1);
    chk("model_7_13_497", modexp(7, 13, 497), 28);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);

    // Basic job with latency and single-pulse start.
    load_key(13, 497);
    mv0 = mv_total;
    send(4); get(0, d, e);
    chk("job1_data", d, 445); chk("job1_err", e, 0);
    chk("job1_issue_lat", issue_cyc - hs_cyc, 1);
    chk("job1_out_lat", ov_cyc - issue_cyc, 3 + core_lat);
    chk("job1_mv", mv_total - mv0, 1);

    // Zero exponent; the stale 445 is still on the core during GUARD.
    core_lat = 2;
    load_key(0, 7);
    send(3); get(0, d, e);
    chk("job2_data", d, 1); chk("job2_err", e, 0);

    load_key(5, 1);
    mv0 = mv_total;
    send(9); get(0, d, e);
    chk("job3_data", d, 0); chk("job3_err", e, 0); chk("job3_mv", mv_total - mv0, 0);

    load_key(5, 0);
    send(5); get(0, d, e);
    chk("job4_data", d, 0); chk("job4_err", e, 1); chk("job4_mv", mv_total - mv0, 0);

    // Dead core: watchdog abort.
    core_dead = 1'b1;
    load_key(13, 497);
    send(4); get(0, d, e);
    chk("timeout_err", e, 1); chk("timeout_data", d, 0);
    chk("timeout_lat", ov_cyc - issue_cyc, TO + 1);
    core_dead = 1'b0;

    // Backpressure for 50 cycles with an ignored key_load inside HOLD.
    send(7); get(50, d, e);
    chk("job6_data", d, 28); chk("job6_err", e, 0);
    send(4); get(0, d, e);
    chk("job7_key_kept", d, 445);

    // Reset during WAIT; the late core result must never surface.
    core_lat = 30;
    load_key(3, 11);
    send(2);
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ov_cnt = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("no_out_after_reset", ov_cnt, 0);

    core_lat = 2;
    send(2); get(0, d, e);
    chk("key_cleared_err", e, 1);
    load_key(3, 11);
    send(3); get(0, d, e);
    chk("post_reset_data", d, 5); chk("post_reset_err", e, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
